// File: rtl/mux_pkg.sv
// Shared constants and the round-robin search helper for the N-to-1 mux.
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Upper bound on channel count handled by rr_next.
   localparam int RR_IDX_W = 6;
   localparam int RR_MAX_N = 1 << RR_IDX_W;

   // First requester after ptr, searching ptr+1, ptr+2, ... modulo n.
   // Iterates from the far end so the nearest requester is written last.
   // Returns ptr when nothing requests; the caller gates with |req.
   function automatic int unsigned rr_next(input logic [RR_MAX_N-1:0] req,
                                           input int unsigned n,
                                           input int unsigned ptr);
      int unsigned idx;
      rr_next = ptr;
      for (int unsigned k = RR_MAX_N; k >= 1; k--) begin
         if (k <= n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (req[idx[RR_IDX_W-1:0]]) rr_next = idx;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant; the pointer register lives in the parent.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N    = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] grant,
   output logic            hit
);

   logic [RR_MAX_N-1:0] req_ext;

   assign req_ext = RR_MAX_N'(req);
   assign grant   = SELW'(rr_next(req_ext, N, 32'(ptr)));
   assign hit     = |req;

endmodule

// File: rtl/mux_rr_nx1.sv
// Registered N-to-1 mux with valid/ready on every channel, direct-select or
// round-robin arbitration, and a single output slot.
module mux_rr_nx1
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 8,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               mode,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_ch
);

   // Pad to a power of two so any sel value indexes safely; pads never hit.
   localparam int NPAD = 1 << SELW;

   logic [NPAD-1:0]  valid_pad;
   logic [WIDTH-1:0] data_arr [NPAD];
   logic [SELW-1:0]  rr_grant;
   logic             rr_hit;
   logic [SELW-1:0]  grant;
   logic             grant_hit;
   logic             load_en;

   logic [WIDTH-1:0] out_data_reg;
   logic [SELW-1:0]  out_ch_reg;
   logic             out_valid_reg;
   logic [SELW-1:0]  rr_ptr_reg;

   assign valid_pad = NPAD'(in_valid);

   generate
      for (genvar gi = 0; gi < NPAD; gi++) begin : g_unpack
         if (gi < N) begin : g_real
            assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign data_arr[gi] = '0;
         end
      end
   endgenerate

   rr_arbiter #(.N(N)) u_arb (
      .req   (in_valid),
      .ptr   (rr_ptr_reg),
      .grant (rr_grant),
      .hit   (rr_hit)
   );

   always_comb begin
      load_en   = !out_valid_reg || out_ready;
      grant     = sel;
      grant_hit = valid_pad[sel];
      if (mode == MODE_RR) begin
         grant     = rr_grant;
         grant_hit = rr_hit;
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready[gi] = load_en && grant_hit && (grant == SELW'(gi));
      end
   endgenerate

   // A transfer is load_en && grant_hit: the granted channel is always valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         rr_ptr_reg    <= SELW'(N-1);
      end else if (load_en) begin
         out_valid_reg <= grant_hit;
         if (grant_hit) begin
            out_data_reg <= data_arr[grant];
            out_ch_reg   <= grant;
            if (mode == MODE_RR) rr_ptr_reg <= grant;
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign out_valid = out_valid_reg;

endmodule
